// File: rtl/avalon_timer_pkg.sv
// Purpose : shared register offsets, control/status bit indices and sizing helper for the interval timer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package avalon_timer_pkg;

  // Word offsets inside one channel's 4-word window.
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  // CONTROL bits: ITO/CONT are stored, START/STOP are write-only strobes.
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  // STATUS bits.
  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  // NUM_CH channel windows plus one PRESCALE word.
  function automatic int addr_width(input int num_ch);
    return $clog2(num_ch * 4 + 1);
  endfunction

endpackage

// File: rtl/avalon_multi_interval_timer_if.sv
// Purpose : Avalon-MM slave bus bundle for the interval timer (address/select/write/data/readdata).
// Latency : readdata is registered by the slave, valid one clk after the address.
// Backpressure: none; the slave accepts every access (no waitrequest).
interface avalon_multi_interval_timer_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_multi_interval_timer_channel.sv
// Purpose : one timer channel - down-counter, RUN/TO/CONTROL/PERIOD/SNAP state and level irq.
// Latency : register writes take effect on the strobe clk; PERIOD reload lands one clk later.
// Backpressure: none; strobes are single-cycle and always accepted.
// Ports: tick (prescaled enable), wr_* decoded write strobes, wdata, rd_off -> rd_val (comb), irq.
module timer_channel
  import avalon_timer_pkg::*;
#(
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             wr_status,
  input  logic             wr_control,
  input  logic             wr_period,
  input  logic             wr_snap,
  input  logic [CNT_W-1:0] wdata,
  input  logic [1:0]       rd_off,
  output logic [31:0]      rd_val,
  output logic             irq
);

  logic             run_q, run_d;
  logic             to_q, to_d;
  logic             ito_q, ito_d;
  logic             cont_q, cont_d;
  logic             was_nz_q, was_nz_d;
  logic             force_reload_q, force_reload_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] snap_q, snap_d;

  logic [CNT_W-1:0] cnt_next;
  logic             timeout_evt;
  logic             stop_oneshot;

  always_comb begin
    run_d          = run_q;
    to_d           = to_q;
    ito_d          = ito_q;
    cont_d         = cont_q;
    period_d       = period_q;
    counter_d      = counter_q;
    snap_d         = snap_q;
    was_nz_d       = (counter_q != '0);
    force_reload_d = wr_period;

    // Zero reloads instead of wrapping, so the counter never underflows.
    cnt_next     = (counter_q == '0) ? period_q : counter_q - CNT_W'(1);
    // Only the edge into zero counts; a counter parked at 0 does not retrigger.
    timeout_evt  = (counter_q == '0) & was_nz_q;
    // One-shot stops on the tick that lands on zero, so the counter then holds 0.
    // A restart from 0 reloads PERIOD on its first tick and keeps running.
    stop_oneshot = tick & run_q & ~cont_q & (cnt_next == '0);

    if (tick && run_q) counter_d = cnt_next;
    // Reload from the PERIOD written last clk; the ticked value above used the old one.
    if (force_reload_q) counter_d = period_q;

    if (force_reload_q || stop_oneshot || (wr_control && wdata[CTL_STOP])) run_d = 1'b0;
    // START has priority over every stop source.
    if (wr_control && wdata[CTL_START]) run_d = 1'b1;

    // A timeout in the same clk as a STATUS write is kept.
    to_d = timeout_evt | (to_q & ~wr_status);

    if (wr_control) begin
      ito_d  = wdata[CTL_ITO];
      cont_d = wdata[CTL_CONT];
    end
    if (wr_period) period_d = wdata;
    // Captures the pre-tick value.
    if (wr_snap) snap_d = counter_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q          <= 1'b0;
      to_q           <= 1'b0;
      ito_q          <= 1'b0;
      cont_q         <= 1'b0;
      was_nz_q       <= 1'b0;
      force_reload_q <= 1'b0;
      period_q       <= RST_VAL;
      counter_q      <= RST_VAL;
      snap_q         <= '0;
    end else begin
      run_q          <= run_d;
      to_q           <= to_d;
      ito_q          <= ito_d;
      cont_q         <= cont_d;
      was_nz_q       <= was_nz_d;
      force_reload_q <= force_reload_d;
      period_q       <= period_d;
      counter_q      <= counter_d;
      snap_q         <= snap_d;
    end
  end

  always_comb begin
    rd_val = '0;
    case (rd_off)
      REG_STATUS: begin
        rd_val[ST_TO]  = to_q;
        rd_val[ST_RUN] = run_q;
      end
      REG_CONTROL: begin
        rd_val[CTL_ITO]  = ito_q;
        rd_val[CTL_CONT] = cont_q;
      end
      REG_PERIOD: rd_val = 32'(period_q);
      REG_SNAP:   rd_val = 32'(snap_q);
      default:    rd_val = '0;
    endcase
  end

  assign irq = to_q & ito_q;

endmodule

// File: rtl/avalon_multi_interval_timer.sv
// Purpose : NUM_CH-channel Avalon-MM interval timer with shared prescaler, per-channel and OR'd irq.
// Latency : readdata registered from address every clk (1 clk); irq is a direct flop decode.
// Backpressure: none; every access completes in one clk.
// Ports: clk, reset_n (async active-low), bus (Avalon slave modport), irq[NUM_CH], irq_any.
module avalon_multi_interval_timer
  import avalon_timer_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_W        = 32,
  parameter int          PRESCALE_W   = 8,
  parameter logic [31:0] RESET_PERIOD = 32'h5F5E0F
) (
  input  logic                        clk,
  input  logic                        reset_n,
  avalon_multi_interval_timer_if.slave bus,
  output logic [NUM_CH-1:0]           irq,
  output logic                        irq_any
);

  localparam int                 ADDR_W        = addr_width(NUM_CH);
  localparam logic [ADDR_W-1:0]  PRESCALE_ADDR = ADDR_W'(NUM_CH * 4);
  localparam logic [CNT_W-1:0]   RST_CNT       = RESET_PERIOD[CNT_W-1:0];

  logic                  wr_en;
  logic [1:0]            wr_off;
  logic                  wr_prescale;
  logic                  tick;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [31:0]           readdata_q, readdata_d;
  logic [31:0]           ch_rd [NUM_CH];

  assign wr_en       = bus.chipselect & ~bus.write_n;
  assign wr_off      = bus.address[1:0];
  assign wr_prescale = wr_en & (bus.address == PRESCALE_ADDR);

  // Prescaler runs 0..PRESCALE; the wrap clk is the tick.
  assign tick = (pre_cnt_q == prescale_q);

  always_comb begin
    prescale_d = prescale_q;
    pre_cnt_d  = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
    if (wr_prescale) begin
      prescale_d = bus.writedata[PRESCALE_W-1:0];
      // Restart the tick phase so the new ratio applies from a clean boundary.
      pre_cnt_d  = '0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [ADDR_W-3:0] CH_IDX = (ADDR_W-2)'(c);
    logic ch_hit;
    assign ch_hit = wr_en & (bus.address[ADDR_W-1:2] == CH_IDX);

    timer_channel #(
      .CNT_W   (CNT_W),
      .RST_VAL (RST_CNT)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick       (tick),
      .wr_status  (ch_hit & (wr_off == REG_STATUS)),
      .wr_control (ch_hit & (wr_off == REG_CONTROL)),
      .wr_period  (ch_hit & (wr_off == REG_PERIOD)),
      .wr_snap    (ch_hit & (wr_off == REG_SNAP)),
      .wdata      (bus.writedata[CNT_W-1:0]),
      .rd_off     (bus.address[1:0]),
      .rd_val     (ch_rd[c]),
      .irq        (irq[c])
    );
  end

  // Read mux; unmatched addresses fall through to zero.
  always_comb begin
    readdata_d = '0;
    if (bus.address == PRESCALE_ADDR) readdata_d = 32'(prescale_q);
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.address[ADDR_W-1:2] == (ADDR_W-2)'(c)) readdata_d = ch_rd[c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      readdata_q <= '0;
    end else begin
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq_any      = |irq;

endmodule

// File: tb/tb_avalon_multi_interval_timer.sv
// Purpose : directed self-checking bench for avalon_multi_interval_timer (2 channels, 32-bit counters).
// Latency : n/a.
// Backpressure: n/a.
module tb_avalon_multi_interval_timer;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;

  avalon_multi_interval_timer_if #(.ADDR_W(ADDR_W)) bus ();

  avalon_multi_interval_timer #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (32),
    .PRESCALE_W   (8),
    .RESET_PERIOD (32'h5F5E0F)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq),
    .irq_any (irq_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(posedge clk);
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_irq(input int ch, input int max_cyc, output bit seen, output int at);
    seen = 1'b0;
    at   = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(posedge clk);
      #1;
      if (irq[ch] === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #12;
    checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %h want 0", bus.readdata); end
    checks++; if (irq !== 2'b00) begin errors++; $display("FAIL rst_irq: got %b want 00", irq); end
    checks++; if (irq_any !== 1'b0) begin errors++; $display("FAIL rst_irq_any: got %b want 0", irq_any); end
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(4'd2, d);
    checks++; if (d !== 32'h5F5E0F) begin errors++; $display("FAIL rst_period0: got %h want 005f5e0f", d); end
    bus_read(4'd6, d);
    checks++; if (d !== 32'h5F5E0F) begin errors++; $display("FAIL rst_period1: got %h want 005f5e0f", d); end
    bus_read(4'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status0: got %h want 0", d); end
    bus_read(4'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_control0: got %h want 0", d); end
    bus_read(4'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_snap0: got %h want 0", d); end
    bus_read(4'd8, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_prescale: got %h want 0", d); end
  endtask

  task automatic test_continuous();
    bit seen;
    int t0, t1, t2;
    bus_write(4'd2, 32'd5);
    bus_write(4'd1, 32'h7);
    t0 = cyc;
    wait_irq(0, 20, seen, t1);
    checks++; if (!seen || (t1 - t0) != 6) begin errors++; $display("FAIL cont_first_irq: seen=%0d after %0d clk want 6", seen, t1 - t0); end
    checks++; if (irq_any !== 1'b1) begin errors++; $display("FAIL cont_irq_any: got %b want 1", irq_any); end
    bus_write(4'd0, 32'h0);
    checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL cont_irq_clear: got %b want 0", irq[0]); end
    wait_irq(0, 20, seen, t2);
    checks++; if (!seen || (t2 - t1) != 6) begin errors++; $display("FAIL cont_spacing: seen=%0d spacing %0d want 6", seen, t2 - t1); end
    bus_write(4'd1, 32'h8);
    bus_write(4'd0, 32'h0);
    checks++; if (irq !== 2'b00 || irq_any !== 1'b0) begin errors++; $display("FAIL cont_stop_irq: got irq=%b any=%b want 00/0", irq, irq_any); end
  endtask

  task automatic test_one_shot();
    bit seen;
    int t0, t1;
    logic [31:0] d;
    bus_write(4'd6, 32'd3);
    bus_write(4'd5, 32'h5);
    t0 = cyc;
    wait_irq(1, 20, seen, t1);
    checks++; if (!seen || (t1 - t0) != 4) begin errors++; $display("FAIL oneshot_irq: seen=%0d after %0d clk want 4", seen, t1 - t0); end
    checks++; if (irq !== 2'b10 || irq_any !== 1'b1) begin errors++; $display("FAIL oneshot_irq_vec: got irq=%b any=%b want 10/1", irq, irq_any); end
    bus_read(4'd4, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL oneshot_status: got %h want 1", d); end
    bus_write(4'd7, 32'h0);
    bus_read(4'd7, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oneshot_hold0: got %h want 0", d); end
    bus_write(4'd4, 32'h0);
    bus_read(4'd4, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oneshot_to_clear: got %h want 0", d); end
    // Restart from 0: reload, 3 decrements to 0, event in the clk after; clear lands on that clk.
    bus_write(4'd5, 32'h5);
    idle(4);
    bus_write(4'd4, 32'h0);
    checks++; if (irq[1] !== 1'b1) begin errors++; $display("FAIL oneshot_race_irq: got %b want 1", irq[1]); end
    bus_read(4'd4, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL oneshot_race_status: got %h want 1", d); end
    bus_write(4'd4, 32'h0);
  endtask

  task automatic test_prescale();
    bit seen;
    int t0, t1, t2;
    bus_write(4'd8, 32'd3);
    bus_write(4'd2, 32'd2);
    bus_write(4'd1, 32'h7);
    t0 = cyc;
    wait_irq(0, 40, seen, t1);
    checks++; if (!seen || (t1 - t0) != 7) begin errors++; $display("FAIL pre_first_irq: seen=%0d after %0d clk want 7", seen, t1 - t0); end
    bus_write(4'd0, 32'h0);
    wait_irq(0, 40, seen, t2);
    checks++; if (!seen || (t2 - t1) != 12) begin errors++; $display("FAIL pre_spacing: seen=%0d spacing %0d want 12", seen, t2 - t1); end
    bus_write(4'd0, 32'h0);
    bus_write(4'd8, 32'd3);
    t0 = cyc;
    wait_irq(0, 40, seen, t1);
    checks++; if (!seen || (t1 - t0) != 13) begin errors++; $display("FAIL pre_phase_restart: seen=%0d after %0d clk want 13", seen, t1 - t0); end
    bus_write(4'd1, 32'h8);
    bus_write(4'd8, 32'd0);
    bus_write(4'd0, 32'h0);
  endtask

  task automatic test_snap_period();
    logic [31:0] d;
    bus_write(4'd2, 32'd100);
    bus_write(4'd1, 32'h6);
    idle(60);
    bus_write(4'd3, 32'h0);
    bus_read(4'd3, d);
    checks++; if (d !== 32'd40) begin errors++; $display("FAIL snap_40: got %0d want 40", d); end
    bus_write(4'd2, 32'd7);
    bus_read(4'd0, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL period_run_still: got %h want 2", d); end
    bus_read(4'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL period_run_clr: got %h want 0", d); end
    bus_write(4'd3, 32'h0);
    bus_read(4'd3, d);
    checks++; if (d !== 32'd7) begin errors++; $display("FAIL period_reload: got %0d want 7", d); end
    bus_read(4'd2, d);
    checks++; if (d !== 32'd7) begin errors++; $display("FAIL period_read: got %0d want 7", d); end
  endtask

  task automatic test_start_stop_unmapped();
    logic [31:0] d;
    bus_write(4'd5, 32'hC);
    bus_read(4'd4, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL start_stop: got %h want 2", d); end
    bus_read(4'd9, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped9: got %h want 0", d); end
    bus_write(4'd9, 32'hFFFF_FFFF);
    bus_read(4'd8, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_wr: got %h want 0", d); end
    bus_read(4'd15, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped15: got %h want 0", d); end
  endtask

  task automatic test_reset_mid_count();
    bit seen;
    int t1;
    logic [31:0] d;
    bus_write(4'd2, 32'd2);
    bus_write(4'd1, 32'h7);
    wait_irq(0, 20, seen, t1);
    checks++; if (!seen) begin errors++; $display("FAIL mid_irq_seen: got %0d want 1", seen); end
    bus_write(4'd8, 32'd5);
    bus_read(4'd8, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL mid_prescale: got %0d want 5", d); end
    checks++; if (irq[0] !== 1'b1) begin errors++; $display("FAIL mid_irq_pre: got %b want 1", irq[0]); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL mid_rst_readdata: got %h want 0", bus.readdata); end
    checks++; if (irq !== 2'b00 || irq_any !== 1'b0) begin errors++; $display("FAIL mid_rst_irq: got irq=%b any=%b want 00/0", irq, irq_any); end
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(4'd2, d);
    checks++; if (d !== 32'h5F5E0F) begin errors++; $display("FAIL mid_rst_period: got %h want 005f5e0f", d); end
    bus_read(4'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_control: got %h want 0", d); end
    bus_read(4'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_status: got %h want 0", d); end
    bus_read(4'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_snap: got %h want 0", d); end
    bus_read(4'd8, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_prescale: got %h want 0", d); end
  endtask

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    test_reset();
    test_continuous();
    test_one_shot();
    test_prescale();
    test_snap_period();
    test_start_stop_unmapped();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
